// File: rtl/huff_pkg.sv
// Shared Huffman definitions: code-length limit, aligner state encoding and window type.
package huff_pkg;

    localparam int MAX_CODE_LEN = 6;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } align_state_t;

    typedef logic [MAX_CODE_LEN-1:0] huff_win_t;

endpackage

// File: rtl/huff_bit_aligner_if.sv
// Stream-in / window-out bundle between the Huffman aligner and its neighbours.
// master: word source + symbol decoder side; slave: the aligner.
interface huff_bit_aligner_if
    import huff_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int WIN_W = MAX_CODE_LEN,
    parameter int BUF_W = 16,
    parameter int CNT_W = $clog2(BUF_W + 1)
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIN_W-1:0] win_data;
    logic             win_valid;
    logic             consume;
    logic [2:0]       consume_len;
    logic [CNT_W-1:0] bit_count;
    logic             stream_done;

    modport master (
        output in_data, in_valid, in_last, consume, consume_len,
        input  in_ready, win_data, win_valid, bit_count, stream_done
    );

    modport slave (
        input  in_data, in_valid, in_last, consume, consume_len,
        output in_ready, win_data, win_valid, bit_count, stream_done
    );
endinterface

// File: rtl/huff_bit_aligner_buf.sv
// huff_bit_buf: MSB-aligned bit buffer with bit count. Each cycle shifts out eff_len
// bits and, on accept, merges the new word directly behind the remaining bits.
// The caller guarantees eff_len <= count and room for the word when accept is high.
module huff_bit_buf
    import huff_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int WIN_W = MAX_CODE_LEN,
    parameter int BUF_W = 16,
    parameter int CNT_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] eff_len_i,
    input  logic             accept_i,
    input  logic [IN_W-1:0]  in_data_i,
    output logic [WIN_W-1:0] win_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_n_o
);
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] shamt;

    // Shift out consumed bits, then place an accepted word right after the survivors.
    always_comb begin
        rem     = count_q - eff_len_i;
        shamt   = CNT_W'(BUF_W - IN_W) - rem;
        buf_d   = buf_q << eff_len_i;
        count_d = rem;
        if (accept_i) begin
            buf_d   = buf_d | (BUF_W'(in_data_i) << shamt);
            count_d = rem + CNT_W'(IN_W);
        end
    end

    // Buffer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    assign win_data_o = buf_q[BUF_W-1 -: WIN_W];
    assign count_o    = count_q;
    assign count_n_o  = count_d;
endmodule

// File: rtl/huff_bit_aligner.sv
// huff_bit_aligner: feeds a Huffman decoder an always-left-aligned window of the
// next unconsumed bits, accepts packed words, drains the tail and flags stream end.
// Optional build macro HUFF_ALIGN_STATS_EN adds stat_bits_in / stat_bits_out counters.
module huff_bit_aligner
    import huff_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int WIN_W = MAX_CODE_LEN,
    parameter int BUF_W = 16,
    parameter int CNT_W = $clog2(BUF_W + 1)
) (
    input  logic        clk,
    input  logic        rst,
    huff_bit_aligner_if.slave bus
`ifdef HUFF_ALIGN_STATS_EN
    ,
    output logic [31:0] stat_bits_in,
    output logic [31:0] stat_bits_out
`endif
);
    align_state_t     state_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q, count_n;
    logic [CNT_W-1:0] len_ext, eff_len;
    logic [CNT_W:0]   fill_after;
    logic             win_valid, in_ready, accept;

    // Clamp the requested length, saturate it to the held bits and derive ready/accept.
    always_comb begin
        len_ext = CNT_W'(bus.consume_len);
        if (len_ext > CNT_W'(WIN_W)) len_ext = CNT_W'(WIN_W);

        case (state_q)
            ST_FILL:  win_valid = (count_q >= CNT_W'(WIN_W));
            ST_DRAIN: win_valid = (count_q != '0);
            default:  win_valid = 1'b0;
        endcase

        eff_len = '0;
        if (bus.consume && win_valid) eff_len = (len_ext > count_q) ? count_q : len_ext;

        fill_after = {1'b0, count_q} - {1'b0, eff_len} + (CNT_W+1)'(IN_W);
        in_ready   = (state_q == ST_FILL) && (fill_after <= (CNT_W+1)'(BUF_W));
        accept     = bus.in_valid && in_ready;
    end

    huff_bit_buf #(
        .IN_W (IN_W),
        .WIN_W(WIN_W),
        .BUF_W(BUF_W),
        .CNT_W(CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .eff_len_i (eff_len),
        .accept_i  (accept),
        .in_data_i (bus.in_data),
        .win_data_o(bus.win_data),
        .count_o   (count_q),
        .count_n_o (count_n)
    );

    // Stream sequencing; stream_done is registered so it is high exactly while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    if (accept && bus.in_last) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (count_n == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.win_valid   = win_valid;
    assign bus.bit_count   = count_q;
    assign bus.stream_done = done_q;

`ifdef HUFF_ALIGN_STATS_EN
    // Running totals of bits entering and leaving; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bits_in  <= '0;
            stat_bits_out <= '0;
        end else begin
            if (accept) stat_bits_in <= stat_bits_in + 32'(IN_W);
            stat_bits_out <= stat_bits_out + 32'(eff_len);
        end
    end
`endif
endmodule
